regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file; next generation of the single-port regfile.
//  Adds N read / M write ports, same-cycle write-to-read bypass, deterministic write-conflict
//  resolution and a per-register busy scoreboard for in-flight producers.
//  Sits in decode/writeback of the core, feeding operand read and hazard detection.
// PARAMETERS
//  XLEN       `XLEN             data width per register
//  AW         `REG_ADDR_WIDTH   address width; DEPTH = 2**AW registers
//  NR         2                 read ports (1..8)
//  NW         1                 write ports (1..4)
//  BYPASS     1                 1: same-cycle write data is forwarded to reads; 0: reads see stored value
//  ZERO_REG   1                 1: register 0 is hardwired to zero, never writable, never busy
// PORTS
//  clk          in   1        clock, all state updates on posedge
//  rst          in   1        asynchronous active-high reset
//  rs_addr      in   NR*AW    read addresses, port i at [i*AW +: AW]
//  rs_data      out  NR*XLEN  read data, combinational
//  rs_busy      out  NR       scoreboard busy bit of the addressed register, combinational
//  rd_wen       in   NW       write enables
//  rd_addr      in   NW*AW    write addresses
//  rd_data      in   NW*XLEN  write data
//  alloc_en     in   1        mark a destination register busy (instruction issued)
//  alloc_addr   in   AW       register to mark busy
//  busy_any     out  1        OR of all busy bits (drain/flush indication)
// BEHAVIOUR
//  - Reset (async, rst=1): every register = 0, every busy bit = 0; rs_data reads 0, rs_busy = 0, busy_any = 0.
//    Writes and allocs are ignored while rst is high; normal operation resumes on the first posedge after deassertion.
//  - Write: on posedge, for each w with rd_wen[w]=1, mem[rd_addr[w]] <= rd_data[w]; 1-cycle latency to the array.
//  - Write conflict: multiple ports to the same address in one cycle -> the highest port index wins.
//  - Read: rs_data[i] = mem[rs_addr[i]], no clock latency.
//    If BYPASS=1 and any enabled write port targets rs_addr[i] this cycle, rs_data[i] = that write's data
//    (highest write index wins, same as the array).
//  - ZERO_REG=1: reads of addr 0 return 0 and rs_busy=0 regardless of bypass; writes/allocs to addr 0 are dropped.
//  - Scoreboard: on posedge, alloc_en sets busy[alloc_addr]; any enabled write clears busy[rd_addr[w]].
//    Alloc and write to the same address in one cycle -> busy ends at 1 (new producer wins).
//  - rs_busy[i] = busy[rs_addr[i]]; if BYPASS=1 and a write to that address is active this cycle, rs_busy[i] = 0.
//    A same-cycle alloc is not visible on rs_busy until the next cycle.
//  - Reset mid-operation: pending writes and allocs in that cycle are discarded; state returns to the reset values.
//  - Addresses are always in range (DEPTH = 2**AW); no wrap or out-of-range handling is required.
// STRUCTURE
//  - `XLEN and `REG_ADDR_WIDTH come from rtl/core/defines.v; add `REGFILE_NR_MAX and `REGFILE_NW_MAX there.
//  - One sub-module: regfile_wsel. It is combinational: given an address, it returns hit, data and
//    the winning port over the NW write ports. It is instantiated once per read port (bypass) and
//    reused for the array-write priority.
//  - Storage: reg array [0:DEPTH-1]. The busy vector is a DEPTH-bit reg.
// TESTING
//  1. Reset: write x5=0x55 and mark it busy. Assert rst for 3 ns mid-cycle.
//     -> x5 reads 0 immediately, busy_any=0, all rs_busy=0.
//  2. Zero reg (ZERO_REG=1): write x0=0xFFFF_FFFF_FFFF_FFFF with the alloc bit set, then read x0.
//     -> rs_data=0, rs_busy=0.
//  3. Bypass (BYPASS=1): write x7=0xDEAD_BEEF_CAFE_BABE and read x7 in the same cycle.
//     -> rs_data shows the new value before the edge.
//     With BYPASS=0 -> the old value 0 before the edge, the new value after it.
//  4. Write conflict (NW=2): port0 writes x3=0x1111, port1 writes x3=0x2222 in the same cycle.
//     -> x3 = 0x2222, and the bypass also shows 0x2222.
//  5. Scoreboard: alloc x9 -> rs_busy=1 next cycle. Write x9 -> busy clears.
//     Alloc and write x9 in the same cycle -> x9 stays busy.
//  6. Sweep with NR=4: write x1..x31 = i*0x0101_0101_0101_0101.
//     -> all 4 ports read every register correctly, including 4 different addresses at once.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared widths and helpers for the multi-port register file.
// Core-wide defines may come from the core defines file; defaults apply only when it is absent.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REGFILE_NR_MAX
`define REGFILE_NR_MAX 8
`endif
`ifndef REGFILE_NW_MAX
`define REGFILE_NW_MAX 4
`endif

package regfile_mp_pkg;

    localparam int unsigned RF_XLEN   = `XLEN;
    localparam int unsigned RF_AW     = `REG_ADDR_WIDTH;
    localparam int unsigned RF_NR_MAX = `REGFILE_NR_MAX;
    localparam int unsigned RF_NW_MAX = `REGFILE_NW_MAX;

    // Width of a write-port index; at least one bit even for a single port.
    function automatic int unsigned port_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Write-port selector: for one address, finds the highest-index enabled write port
// targeting it and returns hit, that port's data and its index.
module regfile_wsel
    import regfile_mp_pkg::*;
#(
    parameter int unsigned NW   = 1,
    parameter int unsigned AW   = RF_AW,
    parameter int unsigned XLEN = RF_XLEN,
    parameter int unsigned PW   = port_w(NW)
) (
    input  logic [AW-1:0]      addr_i,
    input  logic [NW-1:0]      wen_i,
    input  logic [NW*AW-1:0]   waddr_i,
    input  logic [NW*XLEN-1:0] wdata_i,
    output logic               hit_o,
    output logic [XLEN-1:0]    data_o,
    output logic [PW-1:0]      port_o
);

    // Ascending scan so the last match, i.e. the highest port index, wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        port_o = '0;
        for (int w = 0; w < int'(NW); w++) begin
            if (wen_i[w] && (waddr_i[w*AW +: AW] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wdata_i[w*XLEN +: XLEN];
                port_o = PW'(w);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass, highest-port-wins
// write conflicts and a per-register busy scoreboard for in-flight producers.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned AW       = RF_AW,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NR*AW-1:0]   rs_addr,
    output logic [NR*XLEN-1:0] rs_data,
    output logic [NR-1:0]      rs_busy,
    input  logic [NW-1:0]      rd_wen,
    input  logic [NW*AW-1:0]   rd_addr,
    input  logic [NW*XLEN-1:0] rd_data,
    input  logic               alloc_en,
    input  logic [AW-1:0]      alloc_addr,
    output logic               busy_any
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = port_w(NW);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic [NW-1:0]    wen_eff;
    logic [DEPTH-1:0] arr_hit;
    logic [XLEN-1:0]  arr_data [DEPTH];
    logic [PW-1:0]    arr_port_unused [DEPTH];

    // Writes are meaningless while reset is held, including for the bypass path.
    assign wen_eff = rd_wen & {NW{~rst}};

    // Array-write priority: one selector per register resolves conflicts the same way the bypass does.
    for (genvar r = 0; r < int'(DEPTH); r++) begin : g_arr
        regfile_wsel #(
            .NW   (NW),
            .AW   (AW),
            .XLEN (XLEN),
            .PW   (PW)
        ) u_wsel (
            .addr_i  (AW'(r)),
            .wen_i   (wen_eff),
            .waddr_i (rd_addr),
            .wdata_i (rd_data),
            .hit_o   (arr_hit[r]),
            .data_o  (arr_data[r]),
            .port_o  (arr_port_unused[r])
        );
    end

    // Next state: write clears busy, a same-cycle alloc re-marks it (new producer wins).
    always_comb begin
        for (int r = 0; r < int'(DEPTH); r++) begin
            mem_d[r]  = mem_q[r];
            busy_d[r] = busy_q[r];
            if (arr_hit[r]) begin
                mem_d[r]  = arr_data[r];
                busy_d[r] = 1'b0;
            end
            if (alloc_en && (alloc_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
            if ((ZERO_REG != 0) && (r == 0)) begin
                mem_d[r]  = '0;
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_any = |busy_q;

    for (genvar i = 0; i < int'(NR); i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic [PW-1:0]   byp_port_unused;
        logic [XLEN-1:0] data_c;
        logic            busy_c;

        assign addr = rs_addr[i*AW +: AW];

        regfile_wsel #(
            .NW   (NW),
            .AW   (AW),
            .XLEN (XLEN),
            .PW   (PW)
        ) u_wsel (
            .addr_i  (addr),
            .wen_i   (wen_eff),
            .waddr_i (rd_addr),
            .wdata_i (rd_data),
            .hit_o   (byp_hit),
            .data_o  (byp_data),
            .port_o  (byp_port_unused)
        );

        // A forwarded write also means the producer has completed, so busy reads as clear.
        always_comb begin
            data_c = mem_q[addr];
            busy_c = busy_q[addr];
            if ((BYPASS != 0) && byp_hit) begin
                data_c = byp_data;
                busy_c = 1'b0;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data_c = '0;
                busy_c = 1'b0;
            end
        end

        assign rs_data[i*XLEN +: XLEN] = data_c;
        assign rs_busy[i]              = busy_c;
    end

endmodule
